ap_ctrl_hs_driver: RTL
======================

Name: ap_ctrl_hs_driver

Overview:
- Synthesizable initiator for the ap_ctrl_hs block-level handshake; it is the driving end of the start/ready/done protocol that the dataflow monitors observe.
- Launches a programmed number of kernel invocations on one HLS kernel (e.g. add_float_top), with a configurable idle gap between invocations.
- Measures the latency of each invocation and keeps min/max/sum/last statistics and a timeout flag, for on-board runs where no simulation monitor is available.

Parameters:
- CNT_W, 32, width of the latency counter and of the lat_* statistics (lat_sum is 2*CNT_W).
- ITER_W, 16, width of cfg_num_iter and iter_count.
- GAP_W, 8, width of cfg_gap.
- TIMEOUT, 100000, maximum cycles from ap_start to ap_done before the timeout error fires.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; starts a run; ignored unless in IDLE.
- cfg_num_iter  in  ITER_W  invocations per run; sampled on an accepted cfg_start.
- cfg_gap  in  GAP_W  idle cycles between ap_done and the next ap_start; sampled with cfg_num_iter.
- busy  out  1  high from the accepted cfg_start until the run ends.
- run_done  out  1  one-cycle pulse at the end of a run (normal end or timeout).
- timeout_err  out  1  sticky; cleared by the next accepted cfg_start.
- ap_start  out  1  start request to the kernel.
- ap_continue  out  1  held at 1.
- ap_ready  in  1  kernel has accepted its inputs.
- ap_done  in  1  kernel output is valid.
- iter_count  out  ITER_W  completed invocations in the current or last run.
- lat_last  out  CNT_W  latency of the most recent invocation.
- lat_min  out  CNT_W  minimum latency in the run.
- lat_max  out  CNT_W  maximum latency in the run.
- lat_sum  out  2*CNT_W  sum of latencies in the run.

Behaviour:
- Reset values:
  - All outputs 0, except ap_continue = 1 and lat_min = all-ones.
  - State machine in IDLE.
  - Reset is asserted asynchronously and released synchronously; reset mid-run drops ap_start immediately.
- IDLE:
  - cfg_start with cfg_num_iter != 0: latch the config, clear the statistics, clear timeout_err, set busy, go to LAUNCH next cycle.
  - cfg_start with cfg_num_iter == 0: pulse run_done next cycle; busy stays 0; statistics are cleared.
- LAUNCH:
  - ap_start = 1; lat_cnt counts up from 0 on each cycle spent in LAUNCH/WAIT.
  - ap_start stays high until the cycle where ap_ready = 1, then drops on the next edge.
  - ap_ready & ap_done in the same cycle (combinational kernel) means the invocation completes in that cycle: go directly to COMPLETE handling.
  - ap_ready without ap_done: go to WAIT.
- WAIT:
  - ap_start = 0; wait for ap_done. ap_ready in this state is ignored.
- Latency definition:
  - Number of rising edges between the first cycle with ap_start = 1 and the cycle where ap_done = 1.
  - ap_done in the first ap_start cycle gives latency 0.
- Completion (cycle where ap_done is seen):
  - lat_last = lat_cnt; lat_min and lat_max are updated; lat_sum += lat_cnt; iter_count++ (all registered on that edge).
  - If iter_count + 1 == cfg_num_iter: go to IDLE, pulse run_done, drop busy.
  - Otherwise, if cfg_gap == 0: go to LAUNCH (ap_start high on the next cycle, back-to-back).
  - Otherwise go to GAP.
- GAP:
  - A down-counter loaded with cfg_gap; exactly cfg_gap cycles with ap_start = 0, then LAUNCH.
- Timeout:
  - If lat_cnt reaches TIMEOUT in LAUNCH/WAIT without ap_done: set timeout_err, drop ap_start, pulse run_done, go to IDLE.
  - Statistics are not updated for the aborted invocation.
- Saturation:
  - lat_cnt saturates at all-ones and never wraps.
  - lat_sum wraps modulo 2^(2*CNT_W); this is documented and not an error.
- cfg_start while busy is ignored; no queuing.
- A spurious ap_done in IDLE or GAP is ignored and counts nothing.

Test Plan:
- Kernel model with ready at start+0 and done at start+5; cfg_num_iter = 3, cfg_gap = 0 -> three ap_start pulses back-to-back; lat_last = lat_min = lat_max = 5; lat_sum = 15; iter_count = 3; one run_done pulse; busy high throughout.
- Combinational kernel (ready = done = start); cfg_num_iter = 4, cfg_gap = 2 -> each ap_start lasts 1 cycle, 2 idle cycles between starts, all latencies 0, iter_count = 4.
- Kernel delays ap_ready by 3 cycles and ap_done by 7 cycles -> ap_start high exactly 4 cycles; lat_last = 7.
- Kernel latencies 2, 9, 4 -> lat_min = 2, lat_max = 9, lat_sum = 15, lat_last = 4.
- TIMEOUT = 20 and kernel never asserts ap_done -> ap_start drops at lat_cnt = 20; timeout_err = 1; run_done pulses; iter_count = 0; the next cfg_start clears timeout_err.
- reset_n asserted mid-WAIT -> ap_start, busy and the stats go to reset values asynchronously; cfg_num_iter = 0 after reset gives a run_done pulse with no ap_start.

Source files
------------

// File: rtl/ap_ctrl_hs_driver_if.sv
// ap_ctrl_hs block-level handshake bundle between the driver (master) and an HLS kernel (slave).
interface ap_ctrl_hs_driver_if;
  logic ap_start;
  logic ap_continue;
  logic ap_ready;
  logic ap_done;

  modport master (
    output ap_start,
    output ap_continue,
    input  ap_ready,
    input  ap_done
  );

  modport slave (
    input  ap_start,
    input  ap_continue,
    output ap_ready,
    output ap_done
  );
endinterface

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: launches cfg_num_iter kernel invocations separated by cfg_gap idle
// cycles, and records per-invocation latency statistics and a start-to-done timeout.
module ap_ctrl_hs_driver #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ITER_W  = 16,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cfg_start,
  input  logic [ITER_W-1:0]    cfg_num_iter,
  input  logic [GAP_W-1:0]     cfg_gap,
  output logic                 busy,
  output logic                 run_done,
  output logic                 timeout_err,
  ap_ctrl_hs_driver_if.master  ap,
  output logic [ITER_W-1:0]    iter_count,
  output logic [CNT_W-1:0]     lat_last,
  output logic [CNT_W-1:0]     lat_min,
  output logic [CNT_W-1:0]     lat_max,
  output logic [2*CNT_W-1:0]   lat_sum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ITER_W-1:0]   r_cfg_num_iter;
  logic [GAP_W-1:0]    r_cfg_gap;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [CNT_W-1:0]    r_lat_cnt;
  logic [ITER_W-1:0]   r_iter_count;
  logic [CNT_W-1:0]    r_lat_last;
  logic [CNT_W-1:0]    r_lat_min;
  logic [CNT_W-1:0]    r_lat_max;
  logic [2*CNT_W-1:0]  r_lat_sum;
  logic                r_run_done;
  logic                r_timeout_err;

  logic w_accept;
  logic w_zero_run;
  logic w_complete;
  logic w_timeout;
  logic w_last;
  logic w_tmo_hit;
  logic w_lat_clr;

  assign w_last    = (r_iter_count + ITER_W'(1)) == r_cfg_num_iter;
  assign w_tmo_hit = r_lat_cnt >= CNT_W'(TIMEOUT);

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_zero_run = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_num_iter != '0) begin
            w_accept = 1'b1;
            w_next   = S_LAUNCH;
          end else begin
            w_zero_run = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (ap.ap_ready && ap.ap_done) begin
          w_complete = 1'b1;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else if (ap.ap_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ap.ap_done) begin
          w_complete = 1'b1;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_next = S_LAUNCH;
        end
      end
      default: w_next = S_IDLE;
    endcase

    if (w_complete) begin
      if (w_last)                 w_next = S_IDLE;
      else if (r_cfg_gap == '0)   w_next = S_LAUNCH;
      else                        w_next = S_GAP;
    end
  end

  // Latency restarts at 0 on the first cycle of every LAUNCH, including back-to-back relaunches.
  assign w_lat_clr = (w_next == S_LAUNCH) && ((r_state != S_LAUNCH) || w_complete);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cfg_num_iter <= '0;
      r_cfg_gap      <= '0;
      r_gap_cnt      <= '0;
      r_lat_cnt      <= '0;
      r_iter_count   <= '0;
      r_lat_last     <= '0;
      r_lat_min      <= '1;
      r_lat_max      <= '0;
      r_lat_sum      <= '0;
      r_run_done     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_run_done <= w_zero_run | w_timeout | (w_complete & w_last);

      if (w_accept || w_zero_run) begin
        r_cfg_num_iter <= cfg_num_iter;
        r_cfg_gap      <= cfg_gap;
        r_iter_count   <= '0;
        r_lat_last     <= '0;
        r_lat_min      <= '1;
        r_lat_max      <= '0;
        r_lat_sum      <= '0;
        r_timeout_err  <= 1'b0;
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end

      if (w_lat_clr) begin
        r_lat_cnt <= '0;
      end else if ((r_state == S_LAUNCH || r_state == S_WAIT) && (r_lat_cnt != '1)) begin
        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
      end

      if (w_complete) begin
        r_lat_last   <= r_lat_cnt;
        r_iter_count <= r_iter_count + ITER_W'(1);
        r_lat_sum    <= r_lat_sum + {{CNT_W{1'b0}}, r_lat_cnt};
        if (r_lat_cnt < r_lat_min) r_lat_min <= r_lat_cnt;
        if (r_lat_cnt > r_lat_max) r_lat_max <= r_lat_cnt;
      end

      if (w_complete && (w_next == S_GAP)) begin
        r_gap_cnt <= r_cfg_gap;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign ap.ap_start    = (r_state == S_LAUNCH);
  assign ap.ap_continue = 1'b1;
  assign busy           = (r_state != S_IDLE);
  assign run_done       = r_run_done;
  assign timeout_err    = r_timeout_err;
  assign iter_count     = r_iter_count;
  assign lat_last       = r_lat_last;
  assign lat_min        = r_lat_min;
  assign lat_max        = r_lat_max;
  assign lat_sum        = r_lat_sum;

endmodule
